// File: rtl/membus_axi_write.sv
// membus_axi_write: store-path adapter, one membus write -> one AXI4 beat.
// Ports: ACLK/ARESETN; membus slave (mem_*); AXI4 write master (M_AXI_AW*/W*/B*);
//   dram_base address offset; wr_err sticky error flag; wr_count completed writes.
module membus_axi_write #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [31:0]             dram_base,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [31:0]             mem_addr,
  input  logic                    mem_wen,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wmask,
  output logic                    mem_rvalid,
  output logic [31:0]             mem_rdata,
  output logic [AXI_ID_W-1:0]     M_AXI_AWID,
  output logic [AXI_ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWLOCK,
  output logic [3:0]              M_AXI_AWCACHE,
  output logic [2:0]              M_AXI_AWPROT,
  output logic [3:0]              M_AXI_AWQOS,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [AXI_DATA_W-1:0]   M_AXI_WDATA,
  output logic [AXI_DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [AXI_ID_W-1:0]     M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic                    wr_err,
  output logic [31:0]             wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RESP,
    ACK
  } state_e;

  state_e                  state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic [31:0]             addr_q, addr_d;
  logic [AXI_DATA_W-1:0]   wdata_q, wdata_d;
  logic [AXI_DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                    err_q, err_d;
  logic [31:0]             cnt_q, cnt_d;

  // BID is deliberately not checked: only one write is ever outstanding.
  logic unused_bid;
  assign unused_bid = ^M_AXI_BID;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (mem_wen) begin
            // Word-align, then offset into DRAM; wraps mod 2^32.
            addr_d    = dram_base
                      + (mem_addr & 32'hFFFF_FFFC);
            wdata_d   = AXI_DATA_W'(mem_wdata);
            wstrb_d   = (AXI_DATA_W/8)'(mem_wmask);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = SEND;
          end else begin
            state_d = ACK;
          end
        end
      end
      SEND: begin
        // Each channel retires independently on its own handshake.
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (M_AXI_BVALID) begin
          cnt_d   = cnt_q + 32'd1;
          err_d   = err_q | (M_AXI_BRESP != 2'b00);
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_ready     = (state_q == IDLE);
  assign mem_rvalid    = (state_q == ACK);
  assign mem_rdata     = 32'd0;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = AXI_ADDR_W'(addr_q);
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWVALID = awvalid_q;

  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WLAST   = wvalid_q;
  assign M_AXI_WVALID  = wvalid_q;

  assign M_AXI_BREADY  = (state_q == RESP);

  assign wr_err        = err_q;
  assign wr_count      = cnt_q;

endmodule
